// File: rtl/stack_seq_ctrl.sv
// Sequencer for a 256 x 32 single-port scratch stack RAM: stack pointer, PUSH/POP/PEEK/CLEAR
// handshake and RAM pin timing. Optional STACK_HIGHWATER_EN adds a HIGHWATER depth output.
module stack_seq_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [1:0]        CMD_OP,
    input  logic [DATA_W-1:0] CMD_WDATA,
    output logic              RSP_VALID,
    output logic [DATA_W-1:0] RSP_DATA,
    output logic              RSP_ERR,
    output logic [ADDR_W:0]   DEPTH,
    output logic              EMPTY,
    output logic              FULL,
`ifdef STACK_HIGHWATER_EN
    output logic [ADDR_W:0]   HIGHWATER,
`endif
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [DATA_W-1:0] RAM_WDATA,
    output logic              RAM_WEN,
    input  logic [DATA_W-1:0] RAM_RDATA
);

    typedef enum logic [2:0] {IDLE, WRITE, RD_ADDR, RD_WAIT, RESP} state_e;
    typedef enum logic [1:0] {OP_PUSH, OP_POP, OP_PEEK, OP_CLEAR} op_e;

    localparam logic [ADDR_W:0] SP_ONE = (ADDR_W+1)'(1);

    state_e              state_q, state_d;
    logic [ADDR_W:0]     sp_q, sp_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic                ram_wen_q, ram_wen_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic                is_pop_q, is_pop_d;
    logic [ADDR_W:0]     sp_dec;
    logic                full, empty;

    // sp never exceeds 2**ADDR_W, so its MSB alone marks a full stack.
    assign full  = sp_q[ADDR_W];
    assign empty = (sp_q == '0);
    assign sp_dec = sp_q - SP_ONE;

    // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_wen_d   = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        is_pop_d    = is_pop_q;

        unique case (state_q)
            IDLE: begin
                if (CMD_VALID) begin
                    rsp_err_d = 1'b0;
                    unique case (op_e'(CMD_OP))
                        OP_PUSH: begin
                            if (full) begin
                                rsp_err_d = 1'b1;
                                state_d   = RESP;
                            end else begin
                                ram_addr_d  = sp_q[ADDR_W-1:0];
                                ram_wdata_d = CMD_WDATA;
                                ram_wen_d   = 1'b1;
                                state_d     = WRITE;
                            end
                        end
                        OP_POP, OP_PEEK: begin
                            if (empty) begin
                                rsp_err_d = 1'b1;
                                state_d   = RESP;
                            end else begin
                                ram_addr_d = sp_dec[ADDR_W-1:0];
                                is_pop_d   = (op_e'(CMD_OP) == OP_POP);
                                state_d    = RD_ADDR;
                            end
                        end
                        OP_CLEAR: begin
                            sp_d    = '0;
                            state_d = RESP;
                        end
                    endcase
                end
            end
            WRITE: begin
                sp_d    = sp_q + SP_ONE;
                state_d = RESP;
            end
            RD_ADDR: state_d = RD_WAIT;
            // The RAM output register holds the addressed cell by now.
            RD_WAIT: begin
                rsp_data_d = RAM_RDATA;
                if (is_pop_q) sp_d = sp_dec;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            sp_q        <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_wen_q   <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            is_pop_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_wen_q   <= ram_wen_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            is_pop_q    <= is_pop_d;
        end
    end

`ifdef STACK_HIGHWATER_EN
    logic [ADDR_W:0] hw_q, hw_d;

    always_comb begin
        hw_d = hw_q;
        if (sp_d > hw_q) hw_d = sp_d;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) hw_q <= '0;
        else        hw_q <= hw_d;
    end

    assign HIGHWATER = hw_q;
`endif

    // NOTE: the stack RAM itself is external and deliberately never cleared; only the pointer resets.
    assign CMD_READY = (state_q == IDLE) && RST_N;
    assign RSP_VALID = (state_q == RESP);
    assign RSP_DATA  = rsp_data_q;
    assign RSP_ERR   = rsp_err_q;
    assign DEPTH     = sp_q;
    assign EMPTY     = empty;
    assign FULL      = full;
    assign RAM_ADDR  = ram_addr_q;
    assign RAM_WDATA = ram_wdata_q;
    assign RAM_WEN   = ram_wen_q;

endmodule

// File: tb/tb_stack_seq_ctrl.sv
// Self-checking bench for stack_seq_ctrl: vector table, corner sequences and a random run
// against a queue-based stack model. Define STACK_HIGHWATER_EN to also check HIGHWATER.
module tb_stack_seq_ctrl;

    localparam logic [1:0] PUSH = 2'b00, POP = 2'b01, PEEK = 2'b10, CLEAR = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [8:0]  depth;
    logic        empty, full;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_wen;
    logic [31:0] ram_rdata = '0;
`ifdef STACK_HIGHWATER_EN
    logic [8:0]  highwater;
`endif

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [256];
    int unsigned model_q[$];

    always #5 clk = ~clk;

    stack_seq_ctrl #(.DATA_W(32), .ADDR_W(8)) dut (
        .CLK(clk), .RST_N(rst_n),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_OP(cmd_op), .CMD_WDATA(cmd_wdata),
        .RSP_VALID(rsp_valid), .RSP_DATA(rsp_data), .RSP_ERR(rsp_err),
        .DEPTH(depth), .EMPTY(empty), .FULL(full),
`ifdef STACK_HIGHWATER_EN
        .HIGHWATER(highwater),
`endif
        .RAM_ADDR(ram_addr), .RAM_WDATA(ram_wdata), .RAM_WEN(ram_wen), .RAM_RDATA(ram_rdata)
    );

    // Single-port RAM with registered read, read-before-write.
    always @(posedge clk) begin
        if (ram_wen) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_q.delete();
    endtask

    // Issue one command and check response latency, error flag, data, depth and RAM activity.
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [31:0] wd,
                           input logic exp_err, input logic [31:0] exp_data, input logic chk_data,
                           input int exp_depth, input int exp_lat);
        int n = 0;
        int lat = 0;
        int wen_cnt = 0;
        int exp_wen;
        logic [7:0]  seen_addr = '0;
        logic [31:0] seen_wdata = '0;
        int pre_depth;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check({tag, " ready timeout"}, 64'(cmd_ready), 64'd1);
            return;
        end
        pre_depth = int'(depth);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_wdata = wd;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_wdata = $urandom;
        do begin
            @(negedge clk);
            lat++;
            if (ram_wen) begin
                wen_cnt++;
                seen_addr  = ram_addr;
                seen_wdata = ram_wdata;
            end
        end while (!rsp_valid && lat < 10);
        exp_wen = (op == PUSH && !exp_err) ? 1 : 0;
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " rsp_err"}, 64'(rsp_err), 64'(exp_err));
        check({tag, " depth"}, 64'(depth), 64'(exp_depth));
        check({tag, " ram_wen cycles"}, 64'(wen_cnt), 64'(exp_wen));
        if (chk_data) check({tag, " rsp_data"}, 64'(rsp_data), 64'(exp_data));
        if (exp_wen == 1) begin
            check({tag, " ram_addr"}, 64'(seen_addr), 64'(pre_depth[7:0]));
            check({tag, " ram_wdata"}, 64'(seen_wdata), 64'(wd));
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] wd;
        logic        err;
        logic [31:0] data;
        logic        chk;
        int          dep;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{PUSH,  32'hDEADBEEF, 1'b0, 32'h0,        1'b1, 1, 2};
        vecs[1]  = '{POP,   32'h0,        1'b0, 32'hDEADBEEF, 1'b1, 0, 3};
        vecs[2]  = '{POP,   32'h0,        1'b1, 32'h0,        1'b0, 0, 1};
        vecs[3]  = '{PEEK,  32'h0,        1'b1, 32'h0,        1'b0, 0, 1};
        vecs[4]  = '{PUSH,  32'h11,       1'b0, 32'h0,        1'b0, 1, 2};
        vecs[5]  = '{PUSH,  32'h22,       1'b0, 32'h0,        1'b0, 2, 2};
        vecs[6]  = '{POP,   32'h0,        1'b0, 32'h22,       1'b1, 1, 3};
        vecs[7]  = '{POP,   32'h0,        1'b0, 32'h11,       1'b1, 0, 3};
        vecs[8]  = '{PUSH,  32'h5,        1'b0, 32'h0,        1'b0, 1, 2};
        vecs[9]  = '{PEEK,  32'h0,        1'b0, 32'h5,        1'b1, 1, 3};
        vecs[10] = '{CLEAR, 32'h0,        1'b0, 32'h0,        1'b0, 0, 1};
        vecs[11] = '{CLEAR, 32'h0,        1'b0, 32'h0,        1'b0, 0, 1};

        // Reset values while RST_N is held low.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset cmd_ready", 64'(cmd_ready), 64'd0);
        check("reset ram_wen", 64'(ram_wen), 64'd0);
        check("reset ram_addr", 64'(ram_addr), 64'd0);
        check("reset ram_wdata", 64'(ram_wdata), 64'd0);
        check("reset rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset rsp_err", 64'(rsp_err), 64'd0);
        check("reset rsp_data", 64'(rsp_data), 64'd0);
        check("reset depth", 64'(depth), 64'd0);
        check("reset empty", 64'(empty), 64'd1);
        do_reset();

        for (int i = 0; i < 12; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].wd, vecs[i].err,
                    vecs[i].data, vecs[i].chk, vecs[i].dep, vecs[i].lat);
        end
        @(negedge clk);
        check("vec end empty", 64'(empty), 64'd1);

        // PUSH 5, PEEK, CLEAR from a fresh reset; high-water mark reflects depth 1.
        do_reset();
        run_cmd("hw push", PUSH, 32'h5, 1'b0, 32'h0, 1'b0, 1, 2);
        run_cmd("hw peek", PEEK, 32'h0, 1'b0, 32'h5, 1'b1, 1, 3);
        run_cmd("hw clear", CLEAR, 32'h0, 1'b0, 32'h0, 1'b0, 0, 1);
`ifdef STACK_HIGHWATER_EN
        check("highwater after clear", 64'(highwater), 64'd1);
`endif

        // Fill to capacity, reject the overflow push, then PEEK the top.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            run_cmd($sformatf("fill%0d", i), PUSH, 32'(i), 1'b0, 32'h0, 1'b0, i + 1, 2);
        end
        check("full after 256", 64'(full), 64'd1);
        check("empty after 256", 64'(empty), 64'd0);
        run_cmd("overflow push", PUSH, 32'hBADBAD, 1'b1, 32'h0, 1'b0, 256, 1);
        check("mem0 intact", 64'(mem[0]), 64'd0);
        check("full after overflow", 64'(full), 64'd1);
        run_cmd("peek top", PEEK, 32'h0, 1'b0, 32'hFF, 1'b1, 256, 3);
`ifdef STACK_HIGHWATER_EN
        check("highwater full", 64'(highwater), 64'd256);
`endif

        // Reset asserted during the WRITE cycle of a PUSH aborts it.
        do_reset();
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = PUSH;
        cmd_wdata = 32'hCAFE;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        check("abort wen during write", 64'(ram_wen), 64'd1);
        @(negedge clk);
        check("abort wen after reset", 64'(ram_wen), 64'd0);
        check("abort rsp_valid", 64'(rsp_valid), 64'd0);
        check("abort depth", 64'(depth), 64'd0);
        check("abort ready in reset", 64'(cmd_ready), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("abort ready after release", 64'(cmd_ready), 64'd1);
        check("abort no late rsp", 64'(rsp_valid), 64'd0);
        model_q.delete();

        // Random commands against a queue model of the stack.
        for (int k = 0; k < 300; k++) begin
            int unsigned r = $urandom_range(0, 99);
            logic [1:0]  op;
            logic [31:0] wd = $urandom;
            logic        e_err = 1'b0;
            logic [31:0] e_data = '0;
            logic        e_chk = 1'b0;
            int          e_lat;
            op = (r < 45) ? PUSH : (r < 75) ? POP : (r < 93) ? PEEK : CLEAR;
            case (op)
                PUSH: begin
                    if (model_q.size() == 256) e_err = 1'b1;
                    else model_q.push_back(wd);
                    e_lat = e_err ? 1 : 2;
                end
                POP, PEEK: begin
                    if (model_q.size() == 0) e_err = 1'b1;
                    else begin
                        e_data = model_q[model_q.size() - 1];
                        e_chk  = 1'b1;
                        if (op == POP) void'(model_q.pop_back());
                    end
                    e_lat = e_err ? 1 : 3;
                end
                default: begin
                    model_q.delete();
                    e_lat = 1;
                end
            endcase
            run_cmd($sformatf("rand%0d", k), op, wd, e_err, e_data, e_chk, model_q.size(), e_lat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
